// File: rtl/mcash_req_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : mcash_req_gen_if
// Desc     : Per-channel mcash request/return handshake bundle. Channel c
//            occupies slice [c*W +: W] of every packed bus.
// Revision : 1.0 - initial release
// ============================================================================
interface mcash_req_gen_if #(
   parameter int CH_NUM = 3
);
   logic [CH_NUM-1:0]       req_valid;
   logic [CH_NUM-1:0]       req_allowIn;
   logic [CH_NUM*3-1:0]     req_op;
   logic [CH_NUM*28-1:0]    req_addr;
   logic [CH_NUM*128-1:0]   req_data;
   logic [CH_NUM-1:0]       rtn_valid;
   logic [CH_NUM-1:0]       rtn_ready;
   logic [CH_NUM*128-1:0]   rtn_data;

   // Request generator side
   modport master (
      output req_valid, req_op, req_addr, req_data, rtn_ready,
      input  req_allowIn, rtn_valid, rtn_data
   );

   // mcash side
   modport slave (
      input  req_valid, req_op, req_addr, req_data, rtn_ready,
      output req_allowIn, rtn_valid, rtn_data
   );
endinterface
`default_nettype wire

// File: rtl/mcash_req_gen.sv
`default_nettype none
// ============================================================================
// Module   : mcash_req_gen
// Desc     : Plays a preloaded per-channel table of mcash requests, tracks
//            outstanding returns per channel and folds return data into a
//            rotating XOR signature.
// Revision : 1.0 - initial release
// ============================================================================
module mcash_req_gen #(
   parameter int CH_NUM    = 3,
   parameter int DEPTH     = 128,
   parameter int MAX_OUTST = 4
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              start_i,
   input  logic [CH_NUM*$clog2(DEPTH+1)-1:0] cfg_len_i,
   input  logic                              load_valid_i,
   input  logic [2:0]                        load_ch_i,
   input  logic [$clog2(DEPTH)-1:0]          load_idx_i,
   input  logic [158:0]                      load_entry_i,
   mcash_req_gen_if.master                   mc_if,
   output logic                              busy_o,
   output logic                              done_o,
   output logic                              err_o,
   output logic [CH_NUM*128-1:0]             sig_o
);

   localparam int LW = $clog2(DEPTH+1);
   localparam int IW = $clog2(DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic              err_q, err_d;
   logic              w_open;
   logic              w_start;
   logic [CH_NUM-1:0] w_issued;
   logic [CH_NUM-1:0] w_empty;
   logic [CH_NUM-1:0] w_ret_err;

   // Table writes and new runs are only allowed while no run is in flight.
   assign w_open  = (state_q == S_IDLE) || (state_q == S_DONE);
   assign w_start = start_i && w_open;

   assign busy_o          = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done_o          = (state_q == S_DONE);
   assign err_o           = err_q;
   assign mc_if.rtn_ready = {CH_NUM{busy_o}};

   // Run sequencing: issue everything, then wait for every return.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start_i)     state_d = S_RUN;
         S_RUN:          if (&w_issued)   state_d = S_DRAIN;
         S_DRAIN:        if (&w_empty)    state_d = S_DONE;
         default:                         state_d = S_IDLE;
      endcase
   end

   // Error flag is sticky for the whole run and only a new run clears it.
   always_comb begin
      err_d = err_q;
      if (w_start)
         err_d = 1'b0;
      else if (|w_ret_err)
         err_d = 1'b1;
   end

   // Global state registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
      logic [158:0]  mem_q [DEPTH];
      logic [LW-1:0] len_q, ptr_q;
      logic [3:0]    out_q, out_d;
      logic [127:0]  sig_q;
      logic [LW-1:0] w_cfg_len;
      logic [127:0]  w_rtn_data;
      logic [158:0]  w_entry;
      logic          w_valid, w_acc, w_ret;

      assign w_cfg_len  = cfg_len_i[c*LW +: LW];
      assign w_rtn_data = mc_if.rtn_data[c*128 +: 128];
      // ptr == DEPTH only when the channel has nothing left, so the low
      // bits are a safe table index whenever the payload matters.
      assign w_entry    = mem_q[ptr_q[IW-1:0]];

      assign w_valid = (state_q == S_RUN) && (ptr_q < len_q) && (out_q < 4'(MAX_OUTST));
      assign w_acc   = w_valid && mc_if.req_allowIn[c];
      assign w_ret   = busy_o && mc_if.rtn_valid[c];

      assign w_issued[c]  = (ptr_q == len_q);
      assign w_empty[c]   = (out_q == 4'd0);
      assign w_ret_err[c] = w_ret && !w_acc && (out_q == 4'd0);

      assign mc_if.req_valid[c]            = w_valid;
      assign mc_if.req_op[c*3 +: 3]        = w_entry[158:156];
      assign mc_if.req_data[c*128 +: 128]  = w_entry[155:28];
      assign mc_if.req_addr[c*28 +: 28]    = w_entry[27:0];
      assign sig_o[c*128 +: 128]           = sig_q;

      // Request table fill; contents deliberately survive reset.
      always_ff @(posedge clk_i) begin
         if (load_valid_i && w_open && (load_ch_i == 3'(c)))
            mem_q[load_idx_i] <= load_entry_i;
      end

      // Outstanding count; an unexpected return leaves it at zero.
      always_comb begin
         out_d = out_q;
         if (w_acc && !w_ret)
            out_d = out_q + 4'd1;
         else if (w_ret && !w_acc && (out_q != 4'd0))
            out_d = out_q - 4'd1;
      end

      // Per-channel pointer, length, outstanding and signature registers.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            len_q <= '0;
            ptr_q <= '0;
            out_q <= 4'd0;
            sig_q <= 128'd0;
         end else if (w_start) begin
            len_q <= (w_cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : w_cfg_len;
            ptr_q <= '0;
            out_q <= 4'd0;
            sig_q <= 128'd0;
         end else begin
            if (w_acc)
               ptr_q <= ptr_q + LW'(1);
            out_q <= out_d;
            if (w_ret)
               sig_q <= {sig_q[126:0], sig_q[127]} ^ w_rtn_data;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mcash_req_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcash_req_gen
// Desc     : Self-checking bench for mcash_req_gen: directed scenarios plus
//            randomized runs against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcash_req_gen;
   localparam int DP = 16;
   localparam int MO = 4;

   typedef enum int {P_IDLE, P_RUN, P_DRAIN, P_DONE} phase_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start, start2, load_valid;
   logic [14:0]  cfg_len;
   logic [4:0]   cfg2;
   logic [2:0]   load_ch;
   logic [3:0]   load_idx;
   logic [158:0] load_entry;
   logic         busy, done, err, busy2, done2, err2;
   logic [383:0] sig;
   logic [127:0] sig2;

   int errors = 0;
   int checks = 0;

   mcash_req_gen_if #(.CH_NUM(3)) bus ();
   mcash_req_gen_if #(.CH_NUM(1)) bus2 ();

   mcash_req_gen #(.CH_NUM(3), .DEPTH(DP), .MAX_OUTST(MO)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .cfg_len_i(cfg_len),
      .load_valid_i(load_valid), .load_ch_i(load_ch), .load_idx_i(load_idx),
      .load_entry_i(load_entry), .mc_if(bus), .busy_o(busy), .done_o(done),
      .err_o(err), .sig_o(sig));

   mcash_req_gen #(.CH_NUM(1), .DEPTH(DP), .MAX_OUTST(2)) dut2 (
      .clk_i(clk), .rst_i(rst), .start_i(start2), .cfg_len_i(cfg2),
      .load_valid_i(load_valid), .load_ch_i(load_ch), .load_idx_i(load_idx),
      .load_entry_i(load_entry), .mc_if(bus2), .busy_o(busy2), .done_o(done2),
      .err_o(err2), .sig_o(sig2));

   always #5 clk = ~clk;

   // ---------------- reference model (main DUT) ----------------
   phase_t       m_ph;
   logic [158:0] m_tbl [3][16];
   int           m_len [3];
   int           m_ptr [3];
   int           m_out [3];
   logic [127:0] m_sig [3];
   bit           m_err;

   task automatic model_reset();
      m_ph = P_IDLE; m_err = 0;
      for (int c = 0; c < 3; c++) begin
         m_len[c] = 0; m_ptr[c] = 0; m_out[c] = 0; m_sig[c] = '0;
      end
   endtask

   function automatic bit exp_valid(int c);
      return (m_ph == P_RUN) && (m_ptr[c] < m_len[c]) && (m_out[c] < MO);
   endfunction

   // Advances the model by one clock using the inputs currently driven.
   task automatic model_step();
      bit acc [3];
      bit ret [3];
      bit act, all_iss, all_zero;
      act = (m_ph == P_RUN) || (m_ph == P_DRAIN);
      if (load_valid && !act && load_ch < 3) m_tbl[int'(load_ch)][int'(load_idx)] = load_entry;
      if (start && !act) begin
         m_ph = P_RUN; m_err = 0;
         for (int c = 0; c < 3; c++) begin
            m_len[c] = (int'(cfg_len[c*5 +: 5]) > DP) ? DP : int'(cfg_len[c*5 +: 5]);
            m_ptr[c] = 0; m_out[c] = 0; m_sig[c] = '0;
         end
         return;
      end
      all_iss = 1; all_zero = 1;
      for (int c = 0; c < 3; c++) begin
         acc[c] = exp_valid(c) && bus.req_allowIn[c];
         ret[c] = act && bus.rtn_valid[c];
         if (m_ptr[c] != m_len[c]) all_iss = 0;
         if (m_out[c] != 0) all_zero = 0;
      end
      if (m_ph == P_RUN && all_iss) m_ph = P_DRAIN;
      else if (m_ph == P_DRAIN && all_zero) m_ph = P_DONE;
      for (int c = 0; c < 3; c++) begin
         if (ret[c]) m_sig[c] = {m_sig[c][126:0], m_sig[c][127]} ^ bus.rtn_data[c*128 +: 128];
         if (acc[c]) m_ptr[c]++;
         if (acc[c] && !ret[c]) m_out[c]++;
         else if (ret[c] && !acc[c]) begin
            if (m_out[c] == 0) m_err = 1;
            else m_out[c]--;
         end
      end
   endtask

   // ---------------- utilities ----------------
   task automatic tick();
      model_step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      start = 0; start2 = 0; load_valid = 0; load_ch = 0; load_idx = 0; load_entry = '0;
      cfg_len = '0; cfg2 = '0;
      bus.req_allowIn = '0; bus.rtn_valid = '0; bus.rtn_data = '0;
      bus2.req_allowIn = '0; bus2.rtn_valid = '0; bus2.rtn_data = '0;
   endtask

   function automatic logic [127:0] r128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [158:0] r159();
      logic [159:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return t[158:0];
   endfunction

   function automatic logic [158:0] pl(int c);
      return {bus.req_op[c*3 +: 3], bus.req_data[c*128 +: 128], bus.req_addr[c*28 +: 28]};
   endfunction

   task automatic load(int ch, int idx, logic [158:0] e);
      load_valid = 1; load_ch = 3'(ch); load_idx = 4'(idx); load_entry = e;
      tick();
      load_valid = 0;
   endtask

   task automatic finish_run();
      bus.req_allowIn = '1; bus.rtn_valid = '1; bus.rtn_data = {r128(), r128(), r128()};
      for (int i = 0; i < 100 && done !== 1'b1; i++) tick();
      idle_inputs();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL finish_run_timeout: done=%b want 1", done); end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs(); rst = 1; model_reset();
      repeat (2) @(negedge clk);
      #1;
      checks++; if (bus.req_valid !== 3'b000) begin errors++; $display("FAIL reset_req_valid: got %b want 000", bus.req_valid); end
      checks++; if (bus.rtn_ready !== 3'b000) begin errors++; $display("FAIL reset_rtn_ready: got %b want 000", bus.rtn_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
      checks++; if (sig !== 384'd0) begin errors++; $display("FAIL reset_sig: got %h want 0", sig); end
      rst = 0;
      @(negedge clk);
   endtask

   task automatic test_load_all();
      for (int c = 0; c < 3; c++)
         for (int i = 0; i < DP; i++) load(c, i, r159());
   endtask

   task automatic test_basic();
      int acc_cyc [$];
      int ret_cyc [$];
      int done_cyc, nacc;
      logic [127:0] esig, d;
      bit doret;
      done_cyc = -1; nacc = 0; esig = '0;
      for (int i = 0; i < 4; i++) load(0, i, r159());
      cfg_len = 15'd4; start = 1; tick(); start = 0;
      for (int cyc = 0; cyc < 30 && done_cyc < 0; cyc++) begin
         bus.req_allowIn = 3'b111; bus.rtn_valid = '0; doret = 0;
         foreach (acc_cyc[i]) if (acc_cyc[i] + 2 == cyc) doret = 1;
         if (doret) begin
            d = r128(); bus.rtn_valid[0] = 1; bus.rtn_data = {256'd0, d};
            esig = {esig[126:0], esig[127]} ^ d; ret_cyc.push_back(cyc);
         end
         #1;
         if (done === 1'b1) done_cyc = cyc;
         checks++; if (bus.req_valid[2:1] !== 2'b00) begin errors++; $display("FAIL basic_idle_ch_valid: got %b want 00", bus.req_valid[2:1]); end
         if (bus.req_valid[0] === 1'b1) begin
            checks++; if (nacc > 3 || pl(0) !== m_tbl[0][nacc & 3]) begin errors++; $display("FAIL basic_payload: acc %0d got %h", nacc, pl(0)); end
            acc_cyc.push_back(cyc); nacc++;
         end
         tick();
      end
      idle_inputs();
      checks++; if (nacc != 4) begin errors++; $display("FAIL basic_accepts: got %0d want 4", nacc); end
      checks++; if (acc_cyc.size() != 4 || acc_cyc[3] - acc_cyc[0] != 3) begin errors++; $display("FAIL basic_back_to_back: accepts not on consecutive cycles (%0d seen)", acc_cyc.size()); end
      checks++; if (ret_cyc.size() == 0 || done_cyc != ret_cyc[ret_cyc.size()-1] + 2) begin errors++; $display("FAIL basic_done_latency: done at %0d want last return + 2", done_cyc); end
      checks++; if (sig[127:0] !== esig) begin errors++; $display("FAIL basic_sig0: got %h want %h", sig[127:0], esig); end
   endtask

   task automatic test_outst();
      logic [158:0] e2 [3];
      int n;
      n = 0;
      for (int i = 0; i < 3; i++) begin e2[i] = r159(); load(0, i, e2[i]); end
      cfg2 = 5'd3; start2 = 1; tick(); start2 = 0;
      bus2.req_allowIn = 1'b1;
      for (int i = 0; i < 6; i++) begin #1; if (bus2.req_valid[0] === 1'b1) n++; tick(); end
      #1;
      checks++; if (n != 2) begin errors++; $display("FAIL outst_accepts: got %0d want 2", n); end
      checks++; if (bus2.req_valid !== 1'b0) begin errors++; $display("FAIL outst_valid_low: got %b want 0", bus2.req_valid); end
      bus2.rtn_valid = 1'b1; bus2.rtn_data = r128(); tick(); bus2.rtn_valid = 1'b0; #1;
      checks++; if (bus2.req_valid !== 1'b1) begin errors++; $display("FAIL outst_valid_reraise: got %b want 1", bus2.req_valid); end
      checks++; if ({bus2.req_op, bus2.req_data, bus2.req_addr} !== e2[2]) begin errors++; $display("FAIL outst_payload: got %h want %h", {bus2.req_op, bus2.req_data, bus2.req_addr}, e2[2]); end
      checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL outst_err: got %b want 0", err2); end
      idle_inputs();
   endtask

   task automatic test_stall();
      cfg_len = 15'h0040; start = 1; tick(); start = 0;
      for (int i = 0; i < 5; i++) begin
         bus.req_allowIn = '0; #1;
         checks++; if (bus.req_valid[1] !== 1'b1) begin errors++; $display("FAIL stall_valid: cycle %0d got %b want 1", i, bus.req_valid[1]); end
         checks++; if (pl(1) !== m_tbl[1][0]) begin errors++; $display("FAIL stall_payload: cycle %0d got %h want %h", i, pl(1), m_tbl[1][0]); end
         tick();
      end
      bus.req_allowIn = 3'b010; #1;
      checks++; if (bus.req_valid[1] !== 1'b1) begin errors++; $display("FAIL stall_accept_valid: got %b want 1", bus.req_valid[1]); end
      tick(); bus.req_allowIn = '0; #1;
      checks++; if (pl(1) !== m_tbl[1][1]) begin errors++; $display("FAIL stall_advance: got %h want %h", pl(1), m_tbl[1][1]); end
      finish_run();
   endtask

   task automatic test_err();
      logic [127:0] d;
      cfg_len = 15'd2; start = 1; tick(); start = 0; cfg_len = '0;
      d = r128(); bus.rtn_valid = 3'b001; bus.rtn_data = {256'd0, d}; tick();
      bus.rtn_valid = '0; #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err); end
      checks++; if (sig[127:0] !== d) begin errors++; $display("FAIL err_sig_update: got %h want %h", sig[127:0], d); end
      finish_run(); #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
      cfg_len = 15'd2; start = 1; tick(); start = 0; #1;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear_on_start: got %b want 0", err); end
      bus.req_allowIn = 3'b001; tick();
      bus.rtn_valid = 3'b001; bus.rtn_data = {256'd0, r128()}; tick();
      bus.req_allowIn = '0; bus.rtn_valid = '0;
      repeat (4) tick(); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL err_same_cycle_hold: done=%b busy=%b want 0/1", done, busy); end
      bus.rtn_valid = 3'b001; tick(); bus.rtn_valid = '0; tick(); #1;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL err_single_return_done: got %b want 1", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_no_false_err: got %b want 0", err); end
   endtask

   task automatic test_load_in_run();
      logic [158:0] orig;
      orig = m_tbl[0][0];
      cfg_len = 15'd1; start = 1; tick(); start = 0;
      load_valid = 1; load_ch = 3'd0; load_idx = 4'd0; load_entry = ~orig; tick(); load_valid = 0; #1;
      checks++; if (pl(0) !== orig) begin errors++; $display("FAIL load_in_run_payload: got %h want %h", pl(0), orig); end
      finish_run();
      cfg_len = 15'd1; start = 1; tick(); start = 0; #1;
      checks++; if (bus.req_valid[0] !== 1'b1 || pl(0) !== orig) begin errors++; $display("FAIL load_in_run_rerun: got %h want %h", pl(0), orig); end
      finish_run();
   endtask

   task automatic test_rst_mid();
      cfg_len = {5'd3, 5'd3, 5'd3}; start = 1; tick(); start = 0;
      bus.rtn_valid = 3'b100; bus.rtn_data = {r128(), 256'd0}; tick(); bus.rtn_valid = '0;
      #2; rst = 1; model_reset(); #1;
      checks++; if (bus.req_valid !== 3'b000 || bus.rtn_ready !== 3'b000) begin errors++; $display("FAIL rst_mid_handshake: valid=%b ready=%b want 0", bus.req_valid, bus.rtn_ready); end
      checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_mid_status: busy=%b done=%b err=%b want 0", busy, done, err); end
      checks++; if (sig !== 384'd0) begin errors++; $display("FAIL rst_mid_sig: got %h want 0", sig); end
      @(negedge clk); rst = 0;
      cfg_len = {5'd3, 5'd3, 5'd3}; start = 1; tick(); start = 0; #1;
      checks++; if (bus.req_valid !== 3'b111) begin errors++; $display("FAIL rst_rerun_valid: got %b want 111", bus.req_valid); end
      for (int c = 0; c < 3; c++) begin
         checks++; if (pl(c) !== m_tbl[c][0]) begin errors++; $display("FAIL rst_rerun_entry0: ch%0d got %h want %h", c, pl(c), m_tbl[c][0]); end
      end
      finish_run();
   endtask

   task automatic test_random();
      for (int run = 0; run < 6; run++) begin
         bit fin;
         logic [2:0] ev;
         fin = 0;
         for (int k = 0; k < 10; k++) begin
            load_valid = 1; load_ch = 3'($urandom_range(0, 7)); load_idx = 4'($urandom_range(0, 15));
            load_entry = r159(); tick();
         end
         load_valid = 0;
         cfg_len = 15'($urandom()); start = 1; tick(); start = 0;
         for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            bus.req_allowIn = 3'($urandom_range(0, 7));
            for (int c = 0; c < 3; c++) bus.rtn_valid[c] = ($urandom_range(0, 2) == 0);
            bus.rtn_data = {r128(), r128(), r128()};
            load_valid = ($urandom_range(0, 7) == 0); load_ch = 3'($urandom_range(0, 7));
            load_idx = 4'($urandom_range(0, 15)); load_entry = r159();
            start = ($urandom_range(0, 15) == 0); cfg_len = 15'($urandom());
            #1;
            for (int c = 0; c < 3; c++) ev[c] = exp_valid(c);
            checks++; if (bus.req_valid !== ev) begin errors++; $display("FAIL rand_valid: run %0d cyc %0d got %b want %b", run, cyc, bus.req_valid, ev); end
            for (int c = 0; c < 3; c++) if (ev[c]) begin
               checks++; if (pl(c) !== m_tbl[c][m_ptr[c] % DP]) begin errors++; $display("FAIL rand_payload: run %0d cyc %0d ch%0d got %h", run, cyc, c, pl(c)); end
            end
            checks++; if (bus.rtn_ready !== {3{m_ph == P_RUN || m_ph == P_DRAIN}}) begin errors++; $display("FAIL rand_rtn_ready: got %b", bus.rtn_ready); end
            checks++; if (busy !== (m_ph == P_RUN || m_ph == P_DRAIN) || done !== (m_ph == P_DONE)) begin errors++; $display("FAIL rand_status: busy=%b done=%b phase=%0d", busy, done, m_ph); end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rand_err: got %b want %b", err, m_err); end
            checks++; if (sig !== {m_sig[2], m_sig[1], m_sig[0]}) begin errors++; $display("FAIL rand_sig: run %0d cyc %0d got %h", run, cyc, sig); end
            if (m_ph == P_DONE) fin = 1;
            else tick();
         end
         idle_inputs();
         checks++; if (done !== 1'b1) begin errors++; $display("FAIL rand_done_timeout: run %0d done=%b want 1", run, done); end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load_all();
      test_basic();
      test_outst();
      test_stall();
      test_err();
      test_load_in_run();
      test_rst_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
